// File: rtl/pipe_stage_skid.sv
// Single pipeline stage with valid/ready on both sides and a 2-entry skid buffer.
// in_ready, out_valid and count are registered copies of the next state.
module pipe_stage_skid #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAIN_KEEP = 2'd0,
        MAIN_IN   = 2'd1,
        MAIN_SKID = 2'd2
    } main_src_t;

    state_t             r_state;
    state_t             w_state_nxt;
    main_src_t          w_main_src;
    logic               w_skid_load;
    logic               w_clear;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_count;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Next-state and datapath select; flush overrides any handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_main_src  = MAIN_KEEP;
        w_skid_load = 1'b0;
        w_clear     = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_src  = MAIN_IN;
                        w_state_nxt = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_src  = MAIN_IN;
                    end else if (w_in_fire) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = S_FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        w_main_src  = MAIN_SKID;
                        w_state_nxt = S_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload registers: main drives out_data, skid absorbs the extra entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else if (w_clear) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            case (w_main_src)
                MAIN_IN:   r_main <= in_data;
                MAIN_SKID: r_main <= r_skid;
                default:   r_main <= r_main;
            endcase
            if (w_skid_load) begin
                r_skid <= in_data;
            end
        end
    end

    // Status flags registered from the next state so no ready path crosses the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_count     <= CNT_W'(0);
        end else begin
            r_in_ready  <= (w_state_nxt != S_FULL);
            r_out_valid <= (w_state_nxt != S_EMPTY);
            case (w_state_nxt)
                S_BUSY:  r_count <= CNT_W'(1);
                S_FULL:  r_count <= CNT_W'(2);
                default: r_count <= CNT_W'(0);
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios then random valid/ready traffic,
// checked against a depth-2 FIFO queue model.
module tb_pipe_stage_skid;

    localparam int unsigned WIDTH     = 32;
    localparam logic [31:0] RESET_VAL = 32'hC0DE_0005;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_out;
    logic             last_in_fire;

    pipe_stage_skid #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare visible state to the queue model, then apply this edge's handshakes.
    always @(negedge clk) begin
        logic fi;
        logic fo;
        fi = in_valid & in_ready;
        fo = out_valid & out_ready;
        last_in_fire <= fi;
        if (rst) begin
            exp_q.delete();
            last_out = RESET_VAL;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != 2));
            chk("count", 32'(count), 32'(exp_q.size()));
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
            else                   chk("out_data_idle", out_data, last_out);
            if (flush) begin
                exp_q.delete();
                last_out = RESET_VAL;
            end else begin
                if (fo && exp_q.size() != 0) last_out = exp_q.pop_front();
                if (fi) exp_q.push_back(in_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_fire(input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_in_fire && n < 50);
        if (!last_in_fire) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no in_fire within 50 cycles", name);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        last_out     = RESET_VAL;
        last_in_fire = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        out_ready = 1'b1;

        // Reset held with in_valid high: nothing may be captured.
        repeat (3) cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_data", out_data, RESET_VAL);
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (2) cyc();
        chk("post_rst_count", 32'(count), 32'd0);

        // Streaming at full throughput.
        in_valid = 1'b1;
        in_data  = 32'h11; cyc();
        chk("stream_lat", 32'(out_valid), 32'd1);
        in_data  = 32'h22; cyc();
        in_data  = 32'h33; cyc();
        in_valid = 1'b0;
        repeat (3) cyc();

        // Backpressure: fill, hold a third payload upstream, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1; cyc();
        in_data   = 32'hA2; cyc();
        in_data   = 32'hA3;
        repeat (3) cyc();
        chk("bp_count", 32'(count), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head", out_data, 32'hA1);
        out_ready = 1'b1;
        wait_in_fire("bp_a3");
        in_valid = 1'b0;
        repeat (4) cyc();

        // Flush while FULL with a pending payload.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC1; cyc();
        in_data   = 32'hC2; cyc();
        in_data   = 32'hB7;
        flush     = 1'b1; cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_data", out_data, RESET_VAL);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Flush in BUSY with a same-cycle in_fire: the payload is discarded.
        in_valid = 1'b1;
        in_data  = 32'hD1; out_ready = 1'b0; cyc();
        in_data  = 32'hD2; flush = 1'b1; cyc();
        flush    = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_busy_count", 32'(count), 32'd0);
        repeat (3) cyc();

        // Asynchronous reset pulse mid-cycle while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hE1; cyc();
        in_data   = 32'hE2; cyc();
        in_valid  = 1'b0;
        cyc();
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_data", out_data, RESET_VAL);
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (2) cyc();

        // Random traffic; upstream holds its payload until accepted.
        in_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic rdy_a;
            cyc();
            if (!in_valid || last_in_fire) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_data  = $urandom();
            end
            flush     = ($urandom_range(0, 99) < 2);
            out_ready = 1'b1;
            #1 rdy_a = in_ready;
            out_ready = 1'b0;
            #1 chk("ready_comb", 32'(in_ready), 32'(rdy_a));
            out_ready = ($urandom_range(0, 99) < 55);
        end

        // Drain and confirm the model and DUT both end empty.
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("drain_q", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
